// File: rtl/bus_pkg.sv
// ============================================================================
// Module   : bus_pkg
// Brief    : Shared widths and types for the 16-channel byte bus mux/demux.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package bus_pkg;
  localparam int WIDTH = 8;
  localparam int N     = 16;
  localparam int SEL_W = $clog2(N);

  typedef logic [WIDTH-1:0] byte_t;
  typedef byte_t [N-1:0]    bus_t;
  typedef logic [SEL_W:0]   occ_t;

  function automatic occ_t popcount(input logic [N-1:0] v);
    occ_t c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + occ_t'(v[i]);
    end
    return c;
  endfunction
endpackage

`default_nettype wire

// File: rtl/bus_demux_1_16_if.sv
// ============================================================================
// Module   : bus_demux_1_16_if
// Brief    : Byte-stream input and per-channel output handshake bundle.
//            in_bcast exists only when BUS_DEMUX_BCAST_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface bus_demux_1_16_if;
  import bus_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [SEL_W-1:0]     in_sel;
  byte_t                in_data;
`ifdef BUS_DEMUX_BCAST_EN
  logic                 in_bcast;
`endif
  logic [N-1:0]         out_valid;
  logic [N-1:0]         out_ready;
  bus_t                 out_data;
  occ_t                 occ;

  modport slave (
    input  in_valid,
    input  in_sel,
    input  in_data,
`ifdef BUS_DEMUX_BCAST_EN
    input  in_bcast,
`endif
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output occ
  );

  modport master (
    output in_valid,
    output in_sel,
    output in_data,
`ifdef BUS_DEMUX_BCAST_EN
    output in_bcast,
`endif
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  occ
  );
endinterface

`default_nettype wire

// File: rtl/bus_demux_1_16_slot.sv
// ============================================================================
// Module   : demux_slot
// Brief    : One-entry holding register with valid/ready drain.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_slot
  import bus_pkg::*;
(
  input  wire logic  clk,
  input  wire logic  rst,
  input  wire logic  i_load,
  input  wire byte_t i_data,
  input  wire logic  i_ready,
  output logic       o_valid,
  output logic       o_valid_nxt,
  output byte_t      o_data
);
  logic  r_valid;
  byte_t r_data;

  // The parent only loads when the slot is empty or draining, so load wins.
  assign o_valid_nxt = i_load | (r_valid & ~i_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= o_valid_nxt;
      if (i_load) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

`default_nettype wire

// File: rtl/bus_demux_1_16.sv
// ============================================================================
// Module   : bus_demux_1_16
// Brief    : Byte stream to 16 per-channel holding slots; optional broadcast
//            delivery enabled by BUS_DEMUX_BCAST_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_demux_1_16
  import bus_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  bus_demux_1_16_if.slave bus
);
  logic [N-1:0] w_valid;
  logic [N-1:0] w_valid_nxt;
  logic [N-1:0] w_load;
  bus_t         w_data;
  logic         w_sel_ready;
  logic         w_in_ready;
  logic         w_bcast;
  logic         w_accept;
  occ_t         r_occ;

  // A full slot that drains this cycle may be refilled in the same cycle.
  assign w_sel_ready = ~w_valid[bus.in_sel] | bus.out_ready[bus.in_sel];

`ifdef BUS_DEMUX_BCAST_EN
  logic w_all_ready;
  assign w_all_ready = &(~w_valid | bus.out_ready);
  assign w_bcast     = bus.in_valid & bus.in_bcast;
  assign w_in_ready  = w_bcast ? w_all_ready : w_sel_ready;
`else
  assign w_bcast     = 1'b0;
  assign w_in_ready  = w_sel_ready;
`endif

  assign w_accept = bus.in_valid & w_in_ready;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
      assign w_load[gi] = w_accept & (w_bcast | (bus.in_sel == SEL_W'(gi)));

      demux_slot u_slot (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load[gi]),
        .i_data      (bus.in_data),
        .i_ready     (bus.out_ready[gi]),
        .o_valid     (w_valid[gi]),
        .o_valid_nxt (w_valid_nxt[gi]),
        .o_data      (w_data[gi])
      );
    end
  endgenerate

  // Counting next-state valids keeps occ equal to popcount(out_valid).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= '0;
    end else begin
      r_occ <= popcount(w_valid_nxt);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_data;
  assign bus.occ       = r_occ;
endmodule

`default_nettype wire

// File: tb/tb_bus_demux_1_16.sv
// ============================================================================
// Module   : tb_bus_demux_1_16
// Brief    : Scoreboard bench for bus_demux_1_16 (BUS_DEMUX_BCAST_EN optional).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bus_demux_1_16;
  import bus_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_demux_1_16_if bif();

  bus_demux_1_16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int           total = 0;
  int           bad   = 0;
  logic [N-1:0] mv;
  byte_t        sbq[N][$];
  logic         tb_bcast;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [SEL_W-1:0] sel, input byte_t d,
                       input logic [N-1:0] r, input logic bc);
    bif.in_valid  = v;
    bif.in_sel    = sel;
    bif.in_data   = d;
    bif.out_ready = r;
    tb_bcast      = bc;
`ifdef BUS_DEMUX_BCAST_EN
    bif.in_bcast  = bc;
`endif
  endtask

  // Observe the current cycle on the falling edge, update the model, then step.
  task automatic cyc();
    logic  exp_rdy;
    logic  acc;
    byte_t f;
    @(negedge clk);
    if (rst) begin
      chk("rst_valid", 32'(bif.out_valid), 32'h0);
      chk("rst_occ", 32'(bif.occ), 32'h0);
      chk("rst_data", 32'(|bif.out_data), 32'h0);
      mv = '0;
      for (int i = 0; i < N; i++) sbq[i].delete();
    end else begin
      chk("valid", 32'(bif.out_valid), 32'(mv));
      chk("occ", 32'(bif.occ), 32'($countones(mv)));
      if (bif.in_valid && tb_bcast)
        exp_rdy = &(~mv | bif.out_ready);
      else
        exp_rdy = ~mv[bif.in_sel] | bif.out_ready[bif.in_sel];
      chk("in_ready", 32'(bif.in_ready), 32'(exp_rdy));
      acc = bif.in_valid && exp_rdy;
      for (int i = 0; i < N; i++) begin
        if (mv[i] && bif.out_ready[i]) begin
          if (sbq[i].size() == 0) begin
            chk("sb_underflow", 32'h1, 32'h0);
          end else begin
            f = sbq[i].pop_front();
            chk($sformatf("data%0d", i), 32'(bif.out_data[i]), 32'(f));
          end
          mv[i] = 1'b0;
        end
      end
      if (acc) begin
        for (int i = 0; i < N; i++) begin
          if (tb_bcast || (bif.in_sel == SEL_W'(i))) begin
            sbq[i].push_back(bif.in_data);
            mv[i] = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int left;
    mv = '0;
    rst = 1'b1;
    drive(1'b1, 4'd3, 8'hFF, '1, 1'b0);
    @(posedge clk);
    #1;
    cyc();
    cyc();
    rst = 1'b0;

    // single delivery and stall on a full slot
    drive(1'b1, 4'd5, 8'hA5, '0, 1'b0);
    cyc();
    chk("single_valid", 32'(bif.out_valid), 32'h0020);
    chk("single_data", 32'(bif.out_data[5]), 32'hA5);
    chk("single_occ", 32'(bif.occ), 32'd1);
    drive(1'b1, 4'd5, 8'h77, '0, 1'b0);
    #1;
    chk("full_rdy", 32'(bif.in_ready), 32'h0);
    cyc();
    chk("held", 32'(bif.out_data[5]), 32'hA5);

    // refill while draining
    drive(1'b1, 4'd5, 8'h3C, 16'h0020, 1'b0);
    #1;
    chk("refill_rdy", 32'(bif.in_ready), 32'h1);
    cyc();
    drive(1'b0, 4'd0, 8'h00, '0, 1'b0);
    chk("refill_valid", 32'(bif.out_valid[5]), 32'h1);
    chk("refill_data", 32'(bif.out_data[5]), 32'h3C);
    chk("refill_occ", 32'(bif.occ), 32'd1);
    drive(1'b0, 4'd0, 8'h00, '1, 1'b0);
    cyc();

    // fill all, then drain two at once
    for (int s = 0; s < N; s++) begin
      drive(1'b1, SEL_W'(s), 8'(s), '0, 1'b0);
      cyc();
    end
    chk("fill_valid", 32'(bif.out_valid), 32'hFFFF);
    chk("fill_occ", 32'(bif.occ), 32'd16);
    drive(1'b0, 4'd0, 8'h00, 16'h0208, 1'b0);
    cyc();
    chk("drain2_occ", 32'(bif.occ), 32'd14);
    chk("drain2_valid", 32'(bif.out_valid), 32'hFDF7);
    drive(1'b0, 4'd0, 8'h00, '1, 1'b0);
    cyc();

    // cross traffic: accept on 2 while 7 drains
    drive(1'b1, 4'd7, 8'h17, '0, 1'b0);
    cyc();
    drive(1'b1, 4'd2, 8'h12, 16'h0080, 1'b0);
    cyc();
    chk("cross_occ", 32'(bif.occ), 32'd1);
    chk("cross_valid", 32'(bif.out_valid), 32'h0004);

    for (int k = 0; k < 10000; k++) begin
`ifdef BUS_DEMUX_BCAST_EN
      drive(1'($urandom), SEL_W'($urandom), 8'($urandom), N'($urandom),
            ($urandom_range(0, 15) == 0));
`else
      drive(1'($urandom), SEL_W'($urandom), 8'($urandom), N'($urandom), 1'b0);
`endif
      cyc();
    end
    drive(1'b0, 4'd0, 8'h00, '1, 1'b0);
    cyc();
    cyc();
    left = 0;
    for (int i = 0; i < N; i++) left += sbq[i].size();
    chk("sb_left", 32'(left), 32'd0);

`ifdef BUS_DEMUX_BCAST_EN
    drive(1'b1, 4'd9, 8'h5A, '0, 1'b1);
    cyc();
    chk("bc_valid", 32'(bif.out_valid), 32'hFFFF);
    chk("bc_occ", 32'(bif.occ), 32'd16);
    for (int i = 0; i < N; i++) chk($sformatf("bc_data%0d", i), 32'(bif.out_data[i]), 32'h5A);
    drive(1'b1, 4'd4, 8'hC3, 16'hFFEF, 1'b1);
    #1;
    chk("bc_stall", 32'(bif.in_ready), 32'h0);
    cyc();
    drive(1'b0, 4'd0, 8'h00, '1, 1'b0);
    cyc();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
